// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared stage record, forwarding encodings and match helper for hazard_stall_unit
package pipeline_pkg;

    localparam int REG_W = 4;
    localparam logic [REG_W-1:0] PC_REG = 4'hF;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             rf_e;
        logic             load;
    } stage_rec_t;

    // PC reads are never forwarded from, nor stalled on, a younger producer
    function automatic logic stage_match(
        input logic             use_src,
        input logic [REG_W-1:0] src,
        input stage_rec_t       stage,
        input logic [REG_W-1:0] pc_idx
    );
        return use_src && stage.valid && stage.rf_e && (stage.rd == src) && (src != pc_idx);
    endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// rtl/hazard_stall_unit_if.sv - ID-stage operand bundle and hazard control outputs
interface hazard_stall_unit_if #(
    parameter int REG_W = 4
);
    logic             id_valid;
    logic [REG_W-1:0] id_rn;
    logic [REG_W-1:0] id_rm;
    logic [REG_W-1:0] id_rd;
    logic             id_use_rn;
    logic             id_use_rm;
    logic             id_use_rd;
    logic             id_rf_e;
    logic             id_load;

    logic             nop_sel;
    logic             pc_le;
    logic             ifid_le;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [1:0]       fwd_c;

    modport master (
        output id_valid, id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd, id_rf_e, id_load,
        input  nop_sel, pc_le, ifid_le, fwd_a, fwd_b, fwd_c
    );

    modport slave (
        input  id_valid, id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd, id_rf_e, id_load,
        output nop_sel, pc_le, ifid_le, fwd_a, fwd_b, fwd_c
    );

endinterface

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - forwarding source select for one ID operand, youngest producer first
module fwd_select
    import pipeline_pkg::*;
#(
    parameter logic [pipeline_pkg::REG_W-1:0] PC_IDX = pipeline_pkg::PC_REG
) (
    input  logic                           id_valid,
    input  logic                           use_src,
    input  logic [pipeline_pkg::REG_W-1:0] src,
    input  stage_rec_t                     ex,
    input  stage_rec_t                     mem,
    input  stage_rec_t                     wb,
    output logic [1:0]                     sel
);

    always_comb begin
        sel = FWD_RF;
        if (id_valid) begin
            // a load in EX has no data yet; the stall covers it
            if (stage_match(use_src, src, ex, PC_IDX) && !ex.load) begin
                sel = FWD_EX;
            end else if (stage_match(use_src, src, mem, PC_IDX)) begin
                sel = FWD_MEM;
            end else if (stage_match(use_src, src, wb, PC_IDX)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use stall and forwarding control; HAZARD_STATS_EN adds stall_count
module hazard_stall_unit #(
    parameter int               REG_W  = pipeline_pkg::REG_W,
    parameter logic [REG_W-1:0] PC_REG = pipeline_pkg::PC_REG
) (
    input  logic                clk,
    input  logic                reset,
    hazard_stall_unit_if.slave  hz
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]         stall_count
`endif
);
    import pipeline_pkg::*;

    stage_rec_t       ex_q;
    stage_rec_t       mem_q;
    stage_rec_t       wb_q;
    stage_rec_t       id_rec;
    logic             stall;
    logic [REG_W-1:0] src_idx [3];
    logic             src_use [3];
    logic [1:0]       src_sel [3];

    assign id_rec = '{valid: hz.id_valid, rd: hz.id_rd, rf_e: hz.id_rf_e, load: hz.id_load};

    assign src_idx[0] = hz.id_rn;
    assign src_idx[1] = hz.id_rm;
    assign src_idx[2] = hz.id_rd;
    assign src_use[0] = hz.id_use_rn;
    assign src_use[1] = hz.id_use_rm;
    assign src_use[2] = hz.id_use_rd;

    always_comb begin
        stall = 1'b0;
        if (hz.id_valid && ex_q.load) begin
            for (int i = 0; i < 3; i++) begin
                if (stage_match(src_use[i], src_idx[i], ex_q, PC_REG)) begin
                    stall = 1'b1;
                end
            end
        end
    end

    assign hz.nop_sel = stall;
    assign hz.pc_le   = ~stall;
    assign hz.ifid_le = ~stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= stall ? stage_rec_t'('0) : id_rec;
        end
    end

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_fwd
            fwd_select #(.PC_IDX(PC_REG)) u_fwd (
                .id_valid (hz.id_valid),
                .use_src  (src_use[g]),
                .src      (src_idx[g]),
                .ex       (ex_q),
                .mem      (mem_q),
                .wb       (wb_q),
                .sel      (src_sel[g])
            );
        end
    endgenerate

    assign hz.fwd_a = src_sel[0];
    assign hz.fwd_b = src_sel[1];
    assign hz.fwd_c = src_sel[2];

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule
